// File: rtl/delay_line_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : delay_line_pkg
//  Description : Shared constants and helpers for the variable delay line.
//  Revision    : 1.0  initial release
// ============================================================================
package delay_line_pkg;

   // Ceiling log2 for constant expressions (value >= 2 in practice)
   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   localparam int c_DEF_N         = 11;
   localparam int c_DEF_MAX_DELAY = 32;
   localparam int c_DEF_DLY_W     = 6;
   localparam int PTR_W           = clog2(c_DEF_MAX_DELAY);

endpackage
`default_nettype wire

// File: rtl/delay_line_ram.sv
`default_nettype none
// ============================================================================
//  Module      : delay_line_ram
//  Description : DEPTH x (W+1) circular storage. Data words have a synchronous
//                write and no reset; the valid tags have an async reset and a
//                bulk clear. The read port is write-first so a read of the
//                slot being written returns the incoming word (delay of 1).
//  Revision    : 1.0  initial release
// ============================================================================
module delay_line_ram
   import delay_line_pkg::*;
#(
   parameter int W     = c_DEF_N,
   parameter int DEPTH = c_DEF_MAX_DELAY,
   parameter int AW    = PTR_W
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_we,
   input  logic          i_clr,
   input  logic [AW-1:0] i_waddr,
   input  logic [W-1:0]  i_wdata,
   input  logic          i_wtag,
   input  logic [AW-1:0] i_raddr,
   output logic [W-1:0]  o_rdata,
   output logic          o_rtag
);

   logic [W-1:0]     r_mem [DEPTH];
   logic [DEPTH-1:0] r_tag;

   // Sample storage: written on enabled edges, contents never reset
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   // Valid tags: bulk clear on flush, but the word written on the same edge keeps its tag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tag <= '0;
      end else begin
         if (i_clr) r_tag <= '0;
         if (i_we)  r_tag[i_waddr] <= i_wtag;
      end
   end

   // Read port with write-first bypass
   always_comb begin
      o_rdata = r_mem[i_raddr];
      o_rtag  = r_tag[i_raddr];
      if (i_we && (i_raddr == i_waddr)) begin
         o_rdata = i_wdata;
         o_rtag  = i_wtag;
      end
   end

endmodule
`default_nettype wire

// File: rtl/delay_line_var.sv
`default_nettype none
// ============================================================================
//  Module      : delay_line_var
//  Description : Runtime-programmable delay line for signed samples with a
//                valid tag. Delay d (clamped to 1..MAX_DELAY) is the number of
//                enabled edges from input sample to registered output.
//                Changing d flushes all in-flight samples except the one
//                written on the change edge.
//                Optional macro DELAY_LINE_CE_EN adds clock enable port ce.
//  Revision    : 1.0  initial release
// ============================================================================
module delay_line_var
   import delay_line_pkg::*;
#(
   parameter int N         = c_DEF_N,
   parameter int MAX_DELAY = c_DEF_MAX_DELAY,
   parameter int DLY_W     = c_DEF_DLY_W
) (
   input  logic                clk,
   input  logic                rst_n,
`ifdef DELAY_LINE_CE_EN
   input  logic                ce,
`endif
   input  logic signed [N-1:0] idata,
   input  logic                ivalid,
   input  logic [DLY_W-1:0]    dly,
   output logic signed [N-1:0] odata,
   output logic                ovalid,
   output logic                primed
);

   localparam int               c_PW   = clog2(MAX_DELAY);
   localparam int               c_SW   = DLY_W + 1;
   localparam logic [DLY_W-1:0] c_DMAX = DLY_W'(MAX_DELAY);
   localparam logic [c_PW-1:0]  c_LAST = c_PW'(MAX_DELAY - 1);

   logic             w_en;
   logic [DLY_W-1:0] w_d;
   logic             w_flush;
   logic [c_SW-1:0]  w_sum;
   logic [c_PW-1:0]  w_rd;
   logic [N-1:0]     w_rdata;
   logic             w_rtag;

   logic [c_PW-1:0]  r_wp;
   logic [DLY_W-1:0] r_dly_q;
   logic [DLY_W-1:0] r_cnt;
   logic [N-1:0]     r_odata;
   logic             r_ovalid;

`ifdef DELAY_LINE_CE_EN
   assign w_en = ce;
`else
   assign w_en = 1'b1;
`endif

   // Clamp the requested delay into 1..MAX_DELAY
   always_comb begin
      w_d = dly;
      if (dly == '0)         w_d = DLY_W'(1);
      else if (dly > c_DMAX) w_d = c_DMAX;
   end

   assign w_flush = w_en && (w_d != r_dly_q);

   // Read index (wp - d + 1) mod MAX_DELAY; biased by MAX_DELAY so it never goes negative
   assign w_sum = c_SW'(r_wp) + c_SW'(MAX_DELAY) + c_SW'(1) - c_SW'(w_d);
   assign w_rd  = (w_sum >= c_SW'(MAX_DELAY)) ? c_PW'(w_sum - c_SW'(MAX_DELAY))
                                              : c_PW'(w_sum);

   delay_line_ram #(
      .W     (N),
      .DEPTH (MAX_DELAY),
      .AW    (c_PW)
   ) u_ram (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_we    (w_en),
      .i_clr   (w_flush),
      .i_waddr (r_wp),
      .i_wdata (idata),
      .i_wtag  (ivalid),
      .i_raddr (w_rd),
      .o_rdata (w_rdata),
      .o_rtag  (w_rtag)
   );

   // Write pointer, registered delay and saturating prime counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wp    <= '0;
         r_dly_q <= DLY_W'(1);
         r_cnt   <= '0;
      end else if (w_en) begin
         r_wp    <= (r_wp == c_LAST) ? '0 : r_wp + 1'b1;
         r_dly_q <= w_d;
         if (w_flush)             r_cnt <= '0;
         else if (r_cnt != c_DMAX) r_cnt <= r_cnt + 1'b1;
      end
   end

   // Output register: data loads only on a valid tag, valid forced low on a flush
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_odata  <= '0;
         r_ovalid <= 1'b0;
      end else if (w_en) begin
         if (w_flush) begin
            r_ovalid <= 1'b0;
         end else begin
            r_ovalid <= w_rtag;
            if (w_rtag) r_odata <= w_rdata;
         end
      end
   end

   assign odata  = r_odata;
   assign ovalid = r_ovalid;
   assign primed = (r_cnt >= r_dly_q);

endmodule
`default_nettype wire
